uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter for the serial link path. It replaces the fixed 3-baud, 8N1-only transmitter. The baud divisor, data length (5-8), parity mode and stop-bit count are selected at runtime. Transmit data is accepted through a valid/ready handshake and serialised LSB first, with frame-done and busy status returned to the user-side FIFO/controller.

Parameters:
DIV_W, 16, width of the baud divisor input (bit period in clk cycles)
DATA_W, 8, width of tx_data; maximum supported data length (must be 8)
DIV_MIN, 2, minimum effective bit period; smaller divisor values are clamped to this

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous assert, active-low
bps_div  input  DIV_W  bit period in clk cycles; sampled at frame accept
data_bits  input  2  00=5, 01=6, 10=7, 11=8 data bits; sampled at frame accept
parity_mode  input  2  00=none, 01=odd, 10=even, 11=mark (constant 1); sampled at accept
stop2  input  1  0=one stop bit, 1=two stop bits; sampled at accept
tx_data  input  DATA_W  byte to send; unused upper bits ignored
tx_valid  input  1  user has data
tx_ready  output  1  block can accept; transfer on tx_valid & tx_ready
uart_tx  output  1  serial line, idle high
tx_busy  output  1  frame in progress
uart_tx_end  output  1  one-cycle pulse at end of final stop bit

Behaviour:
- Reset (async, rst_n=0): uart_tx=1, tx_ready=0, tx_busy=0, uart_tx_end=0, FSM=IDLE, all counters 0. First clk edge after release sets tx_ready=1.
- FSM states: IDLE -> START -> DATA -> PARITY (skipped if parity_mode=00) -> STOP -> IDLE.
- IDLE: tx_ready=1, uart_tx=1, tx_busy=0. On a clk edge where tx_valid&tx_ready, latch tx_data, bps_div, data_bits, parity_mode and stop2 into shadow registers, then go to START. tx_ready falls and tx_busy rises on that same edge.
- Effective period N = max(bps_div, DIV_MIN). The baud counter runs 0..N-1; a bit boundary occurs when count==N-1. The counter restarts at 0 on every state entry.
- START: uart_tx=0 for N cycles. uart_tx is registered, so line low starts the cycle after accept.
- DATA: LSB first, D=data_bits+5 bits, each held N cycles. The bit index counter runs 0..D-1.
- PARITY: odd = ~^used data bits; even = ^used data bits; mark = 1. Parity is computed over the latched data bits only, excluding ignored upper bits. Held N cycles.
- STOP: uart_tx=1 for N cycles (stop2=0) or 2N cycles (stop2=1).
- At the final stop-bit boundary: go to IDLE, pulse uart_tx_end=1 for exactly one cycle, tx_busy=0, tx_ready=1 (registered, visible on the following cycle).
- Frame length = (1 + D + P + S)*N cycles, where P∈{0,1} and S∈{1,2}.
- Back-to-back: when tx_valid is held high, the next accept occurs on the first IDLE cycle. This gives exactly one extra idle-high clk between the final stop bit and the next start bit.
- Config or tx_data changes while busy have no effect on the current frame; shadow registers only.
- tx_valid while busy: no accept, no data loss; the user holds tx_valid until ready.
- Reset mid-frame: uart_tx returns to 1 immediately (async), and the frame is abandoned. No uart_tx_end pulse.
- Divisor arithmetic is unsigned DIV_W bits. N-1 never underflows because of the clamp.

Test Plan:
- bps_div=4, 8N1 (data_bits=11, parity=00, stop2=0), tx_data=0xA5 -> uart_tx = 0,1,0,1,0,0,1,0,1,1, each held 4 clk. Frame is 40 clk. uart_tx_end pulses 1 clk at the end; tx_ready returns 1.
- bps_div=3, 7E1, tx_data=0x55 (four ones) -> parity bit 0. Odd mode gives 1. Mark gives 1. Frame is 30 clk.
- bps_div=2, 5N2, tx_data=0xFF -> start, five 1s, two stop bits; frame is 16 clk. Upper data bits do not appear on the line.
- tx_valid held high with two bytes, bps_div=4, 8N1 -> frames separated by exactly one idle-high clk. Changing bps_div mid-frame to 8 affects only the second frame.
- bps_div=0 and bps_div=1 -> each bit is 2 clk (clamped).
- rst_n low during DATA bit 3 -> uart_tx=1 asynchronously; tx_busy=0 and no uart_tx_end pulse. After release, tx_ready=1 on the next edge and a new frame sends correctly.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: divisor, 5-8 data bits, parity and 1/2 stop bits
// are latched at accept; the frame is serialised LSB first on a registered line.
module uart_tx_cfg #(
    parameter int DIV_W   = 16,
    parameter int DATA_W  = 8,
    parameter int DIV_MIN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  bps_div,
    input  logic [1:0]        data_bits,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              uart_tx,
    output logic              tx_busy,
    output logic              uart_tx_end
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    localparam logic [DIV_W-1:0] DIV_MIN_L = DIV_W'(DIV_MIN);

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          idx_q, idx_d;
    logic                tx_q, tx_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                end_q, end_d;

    // Shadow copies of the per-frame configuration, loaded only on accept.
    logic [DATA_W-1:0]   data_q;
    logic [DIV_W-1:0]    nm1_q;
    logic [1:0]          bits_q;
    logic [1:0]          par_q;
    logic                stop2_q;

    logic                load;
    logic                bit_end;
    logic [2:0]          last_idx;
    logic [DATA_W-1:0]   data_used;
    logic                par_bit;
    logic [DIV_W-1:0]    div_eff;

    assign div_eff   = (bps_div < DIV_MIN_L) ? DIV_MIN_L : bps_div;
    assign bit_end   = (cnt_q == nm1_q);
    assign last_idx  = {1'b0, bits_q} + 3'd4;
    assign data_used = data_q & ({DATA_W{1'b1}} >> (2'd3 - bits_q));

    always_comb begin
        unique case (par_q)
            2'b01:   par_bit = ~^data_used;
            2'b10:   par_bit = ^data_used;
            default: par_bit = 1'b1;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q + DIV_W'(1);
        idx_d   = idx_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        end_d   = 1'b0;
        load    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (tx_valid && ready_q) begin
                    load    = 1'b1;
                    state_d = S_START;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                    idx_d   = '0;
                    tx_d    = data_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == last_idx) begin
                        idx_d = '0;
                        if (par_q != 2'b00) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = data_q[idx_q + 3'd1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // idx_q doubles as the stop-bit counter for two-stop frames.
                    if (stop2_q && idx_q == 3'd0) begin
                        idx_d = 3'd1;
                    end else begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        end_d   = 1'b1;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            end_q   <= end_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            nm1_q   <= '0;
            bits_q  <= '0;
            par_q   <= '0;
            stop2_q <= 1'b0;
        end else if (load) begin
            data_q  <= tx_data;
            nm1_q   <= div_eff - DIV_W'(1);
            bits_q  <= data_bits;
            par_q   <= parity_mode;
            stop2_q <= stop2;
        end
    end

    assign uart_tx     = tx_q;
    assign tx_ready    = ready_q;
    assign tx_busy     = busy_q;
    assign uart_tx_end = end_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: stimulus pushes hand-computed line patterns,
// a monitor decodes each frame cycle by cycle and checks framing and status.
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bps_div;
    logic [1:0]  data_bits;
    logic [1:0]  parity_mode;
    logic        stop2;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        uart_tx;
    logic        tx_busy;
    logic        uart_tx_end;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [11:0] pat;    // line bits in send order, first bit at [nbits-1]
        int          nbits;
        int          n;
        int          gap;    // idle-high cycles expected before this start, -1 = unchecked
        bit          abort;
    } exp_t;

    exp_t exp_q[$];
    bit   in_frame = 1'b0;

    uart_tx_cfg #(.DIV_W(16), .DATA_W(8), .DIV_MIN(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bps_div     (bps_div),
        .data_bits   (data_bits),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .uart_tx     (uart_tx),
        .tx_busy     (tx_busy),
        .uart_tx_end (uart_tx_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [11:0] pat, input int nbits, input int n,
                            input int gap, input bit abort);
        exp_t e;
        e.pat = pat; e.nbits = nbits; e.n = n; e.gap = gap; e.abort = abort;
        exp_q.push_back(e);
    endtask

    // Leaves tx_valid high; returns #1 after the accepting edge.
    task automatic send(input logic [15:0] div, input logic [1:0] bits, input logic [1:0] par,
                        input logic s2, input logic [7:0] data);
        int waited = 0;
        bps_div = div; data_bits = bits; parity_mode = par; stop2 = s2; tx_data = data;
        tx_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_ready) break;
            waited++;
            if (waited > 300) begin
                check("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: detects start bits, pops the expected frame and checks it.
    initial begin
        exp_t        e;
        logic [11:0] cap, exp_vec;
        bit          stable, early, aborted, skip, idle_valid;
        int          idle;
        skip = 1'b0; idle_valid = 1'b0; idle = 0;
        forever begin
            if (!skip) @(negedge clk);
            skip = 1'b0;
            if (rst_n !== 1'b1) begin
                idle_valid = 1'b0;
                continue;
            end
            if (uart_tx) begin
                idle++;
                continue;
            end
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
                while (!uart_tx && rst_n) @(negedge clk);
                continue;
            end
            e = exp_q.pop_front();
            in_frame = 1'b1;
            if (e.gap >= 0) check("idle_gap", idle_valid ? idle : -1, e.gap);
            check("busy_at_start", tx_busy, 1);
            check("ready_at_start", tx_ready, 0);
            cap = '0; exp_vec = '0; stable = 1'b1; early = 1'b0; aborted = 1'b0;
            for (int k = 0; k < e.nbits; k++) exp_vec[k] = e.pat[e.nbits-1-k];
            for (int k = 0; k < e.nbits && !aborted; k++) begin
                for (int c = 0; c < e.n && !aborted; c++) begin
                    if (k != 0 || c != 0) @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                    else begin
                        if (c == 0) cap[k] = uart_tx;
                        else if (uart_tx !== cap[k]) stable = 1'b0;
                        if (uart_tx_end) early = 1'b1;
                    end
                end
            end
            if (e.abort) begin
                check("frame_aborted", aborted, 1);
                idle_valid = 1'b0;
            end else if (aborted) begin
                check("unexpected_abort", 32'd1, 32'd0);
                idle_valid = 1'b0;
            end else begin
                check("frame_bits", cap, exp_vec);
                check("bit_stable", stable, 1);
                check("no_early_end", early, 0);
                @(negedge clk);
                check("end_pulse", uart_tx_end, 1);
                check("busy_at_end", tx_busy, 0);
                check("ready_at_end", tx_ready, 1);
                check("line_idle_at_end", uart_tx, 1);
                @(negedge clk);
                check("end_width", uart_tx_end, 0);
                idle = 1; idle_valid = 1'b1; skip = 1'b1;
            end
            in_frame = 1'b0;
        end
    end

    initial begin
        int waited;
        rst_n = 1'b1; tx_valid = 1'b0; bps_div = '0; data_bits = '0;
        parity_mode = '0; stop2 = 1'b0; tx_data = '0;
        #2 rst_n = 1'b0;
        #3;
        check("rst_line", uart_tx, 1);
        check("rst_ready", tx_ready, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_end", uart_tx_end, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("ready_before_first_edge", tx_ready, 0);
        @(posedge clk); #1;
        check("ready_after_release", tx_ready, 1);

        // 8N1 0xA5, N=4
        push_exp(12'b0101001011, 10, 4, -1, 0);
        send(16'd4, 2'b11, 2'b00, 1'b0, 8'hA5); tx_valid = 1'b0;
        // 7E1 / 7O1 / 7M1 0x55, N=3; 0xD5 shows bit 7 is excluded from parity
        push_exp(12'b0101010101, 10, 3, -1, 0);
        send(16'd3, 2'b10, 2'b10, 1'b0, 8'h55); tx_valid = 1'b0;
        push_exp(12'b0101010111, 10, 3, -1, 0);
        send(16'd3, 2'b10, 2'b01, 1'b0, 8'h55); tx_valid = 1'b0;
        push_exp(12'b0101010111, 10, 3, -1, 0);
        send(16'd3, 2'b10, 2'b11, 1'b0, 8'h55); tx_valid = 1'b0;
        push_exp(12'b0101010101, 10, 3, -1, 0);
        send(16'd3, 2'b10, 2'b10, 1'b0, 8'hD5); tx_valid = 1'b0;
        // 5N2 0xFF, N=2
        push_exp(12'b01111111, 8, 2, -1, 0);
        send(16'd2, 2'b00, 2'b00, 1'b1, 8'hFF); tx_valid = 1'b0;
        // 6O1 0x2B, N=5
        push_exp(12'b011010111, 9, 5, -1, 0);
        send(16'd5, 2'b01, 2'b01, 1'b0, 8'h2B); tx_valid = 1'b0;
        // 8E2 0x01, N=2
        push_exp(12'b010000000111, 12, 2, -1, 0);
        send(16'd2, 2'b11, 2'b10, 1'b1, 8'h01); tx_valid = 1'b0;
        // divisor clamp: 0 and 1 both give N=2
        push_exp(12'b0111100001, 10, 2, -1, 0);
        send(16'd0, 2'b11, 2'b00, 1'b0, 8'h0F); tx_valid = 1'b0;
        push_exp(12'b0000011111, 10, 2, -1, 0);
        send(16'd1, 2'b11, 2'b00, 1'b0, 8'hF0); tx_valid = 1'b0;
        // back-to-back; second config/data applied while the first frame is busy
        push_exp(12'b0001111001, 10, 4, -1, 0);
        push_exp(12'b0100000011, 10, 8, 1, 0);
        send(16'd4, 2'b11, 2'b00, 1'b0, 8'h3C);
        send(16'd8, 2'b11, 2'b00, 1'b0, 8'h81); tx_valid = 1'b0;

        // reset during data bit 3 of 0xA5 (line bit 4, cycles 16..19 after accept)
        push_exp(12'b0101001011, 10, 4, -1, 1);
        send(16'd4, 2'b11, 2'b00, 1'b0, 8'hA5); tx_valid = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        check("line_before_rst", uart_tx, 0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_line", uart_tx, 1);
        check("rst_mid_busy", tx_busy, 0);
        check("rst_mid_ready", tx_ready, 0);
        check("rst_mid_end", uart_tx_end, 0);
        repeat (3) begin
            @(negedge clk);
            check("rst_no_end", uart_tx_end, 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_mid_rst", tx_ready, 1);
        check("no_end_after_rst", uart_tx_end, 0);
        push_exp(12'b0010110101, 10, 3, -1, 0);
        send(16'd3, 2'b11, 2'b00, 1'b0, 8'h5A); tx_valid = 1'b0;

        waited = 0;
        while ((exp_q.size() != 0 || in_frame) && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check("drain_timeout", (waited >= 3000) ? 1 : 0, 0);
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
